// File: rtl/bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
//   Sequential binary-to-BCD converter (shift-add-3 / double-dabble) that
//   processes one operand bit per clock. It turns a binary count into a
//   packed BCD word for the downstream doubleBCD stage. It also flags operands
//   above MAX_OK, which doubleBCD cannot accept.
//
// Handshake:
//   A conversion is requested by holding start high on a rising edge while
//   busy is low (state IDLE or DONE). bin_in is captured on that same edge.
//   busy stays high for exactly BIN_W cycles. done then pulses for one cycle,
//   and in that cycle bcd_out and range_err carry the new result. start seen
//   while busy is high is ignored. bcd_out and range_err keep their values
//   until the next done.
//
// Ports:
//   clk        in   1          rising-edge clock
//   reset      in   1          synchronous active-high reset (overrides start)
//   start      in   1          conversion request, sampled only while busy==0
//   bin_in     in   BIN_W      binary operand, captured on an accepted start
//   busy       out  1          conversion in progress (state SHIFT)
//   done       out  1          one-cycle result-valid pulse (state DONE)
//   bcd_out    out  4*DIGITS   packed BCD result, digit 0 in [3:0]
//   range_err  out  1          captured operand was greater than MAX_OK
// -----------------------------------------------------------------------------
module bin2bcd_seq #(
    parameter int          BIN_W  = 9,
    parameter int          DIGITS = 3,
    parameter int unsigned MAX_OK = 499
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  range_err
);

    localparam int ACC_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;

    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   acc_adj;
    logic [ACC_W-1:0]   acc_shift;
    logic [BIN_W-1:0]   bin_sr;
    logic [CNT_W-1:0]   cnt;
    logic               err_pend;
    logic               accept;
    logic               last_shift;

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next state and decoded outputs
    // ---------------------------------------------------------------------
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last_shift = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                // cnt==1 before the edge means it reaches 0 on this edge.
                if (cnt == CNT_W'(1)) begin
                    last_shift = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                // A start in the DONE cycle is accepted directly, so
                // conversions can run back to back with no idle cycle.
                if (start) begin
                    accept     = 1'b1;
                    state_next = SHIFT;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Double-dabble step.
    // Every digit is corrected from its pre-shift value, all digits in
    // parallel. A digit >= 5 becomes 8..12 after +3, which still fits in
    // 4 bits, so no carry passes between digits. The corrected accumulator
    // then takes the next operand MSB as it shifts left.
    // ---------------------------------------------------------------------
    always_comb begin
        acc_adj = acc;
        for (int d = 0; d < DIGITS; d++) begin
            if (acc[4*d +: 4] >= 4'd5) begin
                acc_adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
            end
        end
        acc_shift = {acc_adj[ACC_W-2:0], bin_sr[BIN_W-1]};
    end

    // ---------------------------------------------------------------------
    // Datapath registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            acc       <= '0;
            bin_sr    <= '0;
            cnt       <= '0;
            err_pend  <= 1'b0;
            bcd_out   <= '0;
            range_err <= 1'b0;
        end else begin
            if (accept) begin
                acc      <= '0;
                bin_sr   <= bin_in;
                cnt      <= CNT_W'(BIN_W);
                // The operand is shifted away during conversion, so the range
                // verdict is taken at capture and held until the result is
                // published.
                err_pend <= (32'(bin_in) > MAX_OK);
            end else if (state == SHIFT) begin
                acc    <= acc_shift;
                bin_sr <= {bin_sr[BIN_W-2:0], 1'b0};
                cnt    <= cnt - CNT_W'(1);
            end

            if (last_shift) begin
                bcd_out   <= acc_shift;
                range_err <= err_pend;
            end
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// tb_bin2bcd_seq
//   Directed self-checking bench for bin2bcd_seq. It covers:
//   - reset state, including start being overridden during reset
//   - boundary operands 0 / 499 / 500 / 511
//   - start ignored while busy, and back-to-back start in the DONE cycle
//   - reset in the middle of a conversion
//   - a back-to-back sweep of 0..511 with a check on done spacing
// -----------------------------------------------------------------------------
module tb_bin2bcd_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [8:0]  bin_in;
    logic        busy;
    logic        done;
    logic [11:0] bcd_out;
    logic        range_err;

    int total;
    int bad;

    bin2bcd_seq #(
        .BIN_W  (9),
        .DIGITS (3),
        .MAX_OK (499)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bin_in    (bin_in),
        .busy      (busy),
        .done      (done),
        .bcd_out   (bcd_out),
        .range_err (range_err)
    );

    // ---------------------------------------------------------------------
    // Clock
    // ---------------------------------------------------------------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------------
    // Checking
    // ---------------------------------------------------------------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------------------------------------------------------------
    // Driver helpers. Inputs change and outputs are sampled 1 time unit after
    // each rising edge.
    // ---------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue a start; the accepting edge happens inside this task.
    task automatic issue(input logic [8:0] v);
        bin_in = v;
        start  = 1'b1;
        step();
        start  = 1'b0;
    endtask

    // Count cycles after the accepting edge until done rises (bounded).
    task automatic wait_done(input string tag, output int lat);
        lat = 0;
        while (!done && lat < 30) begin
            step();
            lat++;
        end
        check_eq({tag, "_done_seen"}, 32'(done), 32'(1'b1));
    endtask

    task automatic run_vec(input string tag, input logic [8:0] v,
                           input logic [11:0] exp_bcd, input logic exp_err);
        int lat;
        issue(v);
        check_eq({tag, "_busy"}, 32'(busy), 32'(1'b1));
        wait_done(tag, lat);
        check_eq({tag, "_lat"}, 32'(lat), 32'd9);
        check_eq({tag, "_bcd"}, 32'(bcd_out), 32'(exp_bcd));
        check_eq({tag, "_err"}, 32'(range_err), 32'(exp_err));
        step();
        check_eq({tag, "_done_pulse"}, 32'(done), 32'(1'b0));
        check_eq({tag, "_idle"}, 32'(busy), 32'(1'b0));
        check_eq({tag, "_hold"}, 32'(bcd_out), 32'(exp_bcd));
    endtask

    function automatic logic [11:0] golden(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Directed vectors with hand-computed BCD results.
    localparam int NV = 10;
    localparam logic [8:0]  VEC_IN  [NV] = '{9'd1, 9'd9, 9'd10, 9'd99, 9'd100,
                                            9'd255, 9'd314, 9'd498, 9'd501, 9'd64};
    localparam logic [11:0] VEC_BCD [NV] = '{12'h001, 12'h009, 12'h010, 12'h099, 12'h100,
                                            12'h255, 12'h314, 12'h498, 12'h501, 12'h064};
    localparam logic        VEC_ERR [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                            1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    // ---------------------------------------------------------------------
    // Stimulus
    // ---------------------------------------------------------------------
    initial begin
        int lat;
        int seen;
        total  = 0;
        bad    = 0;
        reset  = 1'b1;
        start  = 1'b1;   // must be overridden by reset
        bin_in = 9'd123;
        step();
        step();
        check_eq("rst_busy", 32'(busy), 32'(1'b0));
        check_eq("rst_done", 32'(done), 32'(1'b0));
        check_eq("rst_bcd", 32'(bcd_out), 32'h000);
        check_eq("rst_err", 32'(range_err), 32'(1'b0));
        reset = 1'b0;
        start = 1'b0;
        step();
        check_eq("post_rst_idle", 32'(busy), 32'(1'b0));

        // Boundary operands.
        run_vec("v0",   9'd0,   12'h000, 1'b0);
        run_vec("v499", 9'd499, 12'h499, 1'b0);
        run_vec("v500", 9'd500, 12'h500, 1'b1);
        run_vec("v511", 9'd511, 12'h511, 1'b1);

        // Reset mid-conversion: bcd_out/range_err hold 511/1 from above.
        issue(9'd256);
        for (int i = 0; i < 4; i++) step();
        check_eq("abort_busy_pre", 32'(busy), 32'(1'b1));
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_eq("abort_busy", 32'(busy), 32'(1'b0));
        check_eq("abort_done", 32'(done), 32'(1'b0));
        check_eq("abort_bcd", 32'(bcd_out), 32'h000);
        check_eq("abort_err", 32'(range_err), 32'(1'b0));
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (done) seen++;
        end
        check_eq("abort_no_done", 32'(seen), 32'd0);
        run_vec("v256", 9'd256, 12'h256, 1'b0);

        // A start while busy is ignored; a start in the DONE cycle is taken.
        issue(9'd123);
        for (int i = 0; i < 3; i++) step();
        bin_in = 9'd77;
        start  = 1'b1;
        step();
        start  = 1'b0;
        bin_in = 9'd400;   // changes during SHIFT must not matter
        seen = 4;
        while (!done && seen < 30) begin
            step();
            seen++;
        end
        check_eq("ign_done_seen", 32'(done), 32'(1'b1));
        check_eq("ign_lat", 32'(seen), 32'd9);
        check_eq("ign_bcd", 32'(bcd_out), 32'h123);
        issue(9'd77);     // accepted in the DONE cycle
        check_eq("b2b_no_double_done", 32'(done), 32'(1'b0));
        check_eq("b2b_busy", 32'(busy), 32'(1'b1));
        wait_done("b2b", lat);
        check_eq("b2b_lat", 32'(lat), 32'd9);
        check_eq("b2b_bcd", 32'(bcd_out), 32'h077);
        step();

        // Assorted directed vectors.
        for (int i = 0; i < NV; i++) begin
            run_vec($sformatf("tbl%0d", i), VEC_IN[i], VEC_BCD[i], VEC_ERR[i]);
        end

        // Back-to-back sweep 0..511: done repeats every 10 cycles and is never
        // high in two consecutive cycles.
        for (int v = 0; v < 512; v++) begin
            issue(9'(v));
            check_eq("sweep_done_low", 32'(done), 32'(1'b0));
            wait_done("sweep", lat);
            check_eq("sweep_spacing", 32'(lat + 1), 32'd10);
            check_eq($sformatf("sweep_bcd_%0d", v), 32'(bcd_out), 32'(golden(v)));
            check_eq($sformatf("sweep_err_%0d", v), 32'(range_err), 32'(v > 499));
        end
        step();
        check_eq("sweep_end_done", 32'(done), 32'(1'b0));
        check_eq("sweep_end_hold", 32'(bcd_out), 32'h511);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
